// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the two byte requesters, the arbiter and the buart transmitter.
// The arbiter connects through the slave modport; the requester/UART side uses master.
interface uart_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_last;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] uart_tx_data;
  logic       uart_wr;
  logic       uart_busy;
  logic [1:0] grant;
  logic       lock_timeout;

  modport master (
    output req0_data, req0_valid, req0_last,
    input  req0_ready,
    output req1_data, req1_valid, req1_last,
    input  req1_ready,
    input  uart_tx_data, uart_wr,
    output uart_busy,
    input  grant, lock_timeout
  );

  modport slave (
    input  req0_data, req0_valid, req0_last,
    output req0_ready,
    input  req1_data, req1_valid, req1_last,
    output req1_ready,
    output uart_tx_data, uart_wr,
    input  uart_busy,
    output grant, lock_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one buart transmitter between two byte sources.
// The owner keeps the UART until its last byte or until it idles for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_W = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {ARB, OWN, ISSUE, SETTLE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             rr_q, rr_d;           // 1: req1 is favoured on a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             lt_q, lt_d;

  logic ready0, ready1;
  logic win;
  logic owner_valid;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    lt_d        = 1'b0;
    ready0      = 1'b0;
    ready1      = 1'b0;
    win         = 1'b0;
    owner_valid = (grant_q[0] & bus.req0_valid) | (grant_q[1] & bus.req1_valid);

    case (state_q)
      ARB: begin
        if (bus.req0_valid | bus.req1_valid) begin
          win     = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
          grant_d = win ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = OWN;
        end
      end

      OWN: begin
        ready0 = grant_q[0] & bus.req0_valid & ~bus.uart_busy;
        ready1 = grant_q[1] & bus.req1_valid & ~bus.uart_busy;
        if (ready0 | ready1) begin
          tx_data_d = ready0 ? bus.req0_data : bus.req1_data;
          last_d    = ready0 ? bus.req0_last : bus.req1_last;
          cnt_d     = '0;
          state_d   = ISSUE;
        end else if (!owner_valid && (LOCK_TIMEOUT != 0)) begin
          // Valid high while busy is back-pressure, not a stall, so only valid-low counts.
          if (cnt_q == CNT_LAST) begin
            lt_d    = 1'b1;
            grant_d = 2'b00;
            rr_d    = grant_q[0];
            cnt_d   = '0;
            state_d = ARB;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ISSUE: state_d = SETTLE;

      SETTLE: begin
        // Gives buart one cycle to raise busy before ready is evaluated again.
        if (last_q || (LOCK_TIMEOUT == 0)) begin
          grant_d = 2'b00;
          rr_d    = grant_q[0];
          state_d = ARB;
        end else begin
          state_d = OWN;
        end
      end

      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      grant_q   <= 2'b00;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      lt_q      <= lt_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.uart_wr      = (state_q == ISSUE);
  assign bus.uart_tx_data = tx_data_q;
  assign bus.grant        = grant_q;
  assign bus.lock_timeout = lt_q;

endmodule
